// File: rtl/mem_b_reader.sv
// mem_b_reader: reads len words from memory B (addresses 0..len-1) and streams
// them out through a 2-entry FIFO with a valid/ready handshake.
//
// Ports:
//   clock, reset (async, active low)
//   start, len          : burst request, sampled in IDLE only
//   addrB, reB, rdataB  : memory B read port, data returns one cycle after reB
//   dout, dout_valid, dout_ready : output stream (FIFO head)
//   busy, done          : burst in progress / one-cycle completion pulse
//   dout_par            : even parity of dout, only with READBACK_PARITY_EN
//
// Optional feature macro: READBACK_PARITY_EN
module mem_b_reader #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addrB,
  output logic          reB,
  input  logic [DW-1:0] rdataB,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
`ifdef READBACK_PARITY_EN
  output logic          dout_par,
`endif
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          inf_q;

  logic [DW-1:0] mem_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    occ_q;

  logic [AW:0]   len_eff;
  logic [AW-1:0] iss_addr;
  logic          issue;
  logic          push, pop;
  logic [1:0]    occ_nx;
  logic          room;

  assign len_eff = (len > DEPTH) ? DEPTH : len;

  assign push = inf_q;
  assign pop  = dout_valid && dout_ready;

  // A word leaving this cycle frees its slot, so count it as gone;
  // otherwise a full-rate stream would stall every other cycle.
  assign occ_nx = occ_q - {1'b0, pop};
  assign room   = (occ_nx + {1'b0, inf_q}) < 2'd2;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    issue    = 1'b0;
    iss_addr = cnt_q[AW-1:0];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = FIN;
          end else begin
            // First read goes out in the accept cycle.
            len_d    = len_eff;
            issue    = 1'b1;
            iss_addr = '0;
            cnt_d    = {{AW{1'b0}}, 1'b1};
            state_d  = READ;
          end
        end
      end
      READ: begin
        if (cnt_q < len_q && room) begin
          issue = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (occ_q == 2'd0 && !inf_q) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign reB        = issue;
  assign addrB      = issue ? iss_addr : addr_q;
  assign dout_valid = occ_q != 2'd0;
  assign dout       = mem_q[rp_q];
  assign busy       = state_q != IDLE;
  assign done       = state_q == FIN;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      inf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      inf_q   <= issue;
      if (issue) addr_q <= iss_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= rdataB;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef READBACK_PARITY_EN
  logic [1:0] par_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q <= '0;
    end else if (push) begin
      par_q[wp_q] <= ^rdataB;
    end
  end

  assign dout_par = par_q[rp_q];
`endif

endmodule

// File: tb/tb_mem_b_reader.sv
// tb_mem_b_reader: directed bench for mem_b_reader with a scoreboard of
// expected read addresses and output words (memory B holds addr+0x10).
module tb_mem_b_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] addrB;
  logic          reB;
  logic [DW-1:0] rdataB = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef READBACK_PARITY_EN
  logic          dout_par;
`endif

  mem_b_reader #(.DW(DW), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .addrB      (addrB),
    .reB        (reB),
    .rdataB     (rdataB),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef READBACK_PARITY_EN
    .dout_par   (dout_par),
`endif
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Memory B model: synchronous read, word = address + 0x10.
  always @(posedge clock) begin
    if (reB) rdataB <= DW'(addrB) + DW'(8'h10);
  end

  int errs = 0;
  int checks = 0;
  int cyc_n = 0;
  int rx_cnt = 0;
  int t0 = 0;
  logic [DW-1:0] exp_d [$];
  logic [AW-1:0] exp_a [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  // Scoreboard: every issued address and every consumed word is checked.
  always @(negedge clock) begin
    if (reset) begin
      if (reB) begin
        chk("addr_expected", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) chk("addrB", 32'(addrB), 32'(exp_a.pop_front()));
      end
      if (dout_valid && dout_ready) begin
        rx_cnt++;
        chk("dout_expected", 32'(exp_d.size() != 0), 1);
        if (exp_d.size() != 0) chk("dout", 32'(dout), 32'(exp_d.pop_front()));
`ifdef READBACK_PARITY_EN
        chk("dout_par", 32'(dout_par), 32'(^dout));
`endif
      end
    end
  end

  task automatic go(int n);
    int k;
    k = (n > 16) ? 16 : n;
    start = 1'b1;
    len   = (AW+1)'(n);
    for (int i = 0; i < k; i++) begin
      exp_d.push_back(DW'(i + 16));
      exp_a.push_back(AW'(i));
    end
    #1;
    chk("reB_at_start", 32'(reB), 32'(n != 0));
    t0 = cyc_n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
  endtask

  initial begin
    int base;
    // Reset state
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_reB", 32'(reB), 0);
    chk("rst_addrB", 32'(addrB), 0);
    chk("rst_dout", 32'(dout), 0);
    reset = 1'b1;
    cyc();

    // len=4, ready high: four words at full rate, then done
    dout_ready = 1'b1;
    go(4);
    chk("s1_valid_t1", 32'(dout_valid), 0);
    cyc();
    chk("s1_valid_t2", 32'(dout_valid), 1);
    chk("s1_dout_t2", 32'(dout), 32'h10);
    cyc();
    chk("s1_dout_t3", 32'(dout), 32'h11);
    wait_done("s1");
    chk("s1_done_cycle", 32'(cyc_n - t0), 7);
    chk("s1_busy_fin", 32'(busy), 1);
    cyc();
    chk("s1_done_pulse", 32'(done), 0);
    chk("s1_busy_idle", 32'(busy), 0);
    chk("s1_sb_empty", 32'(exp_d.size() + exp_a.size()), 0);

    // len=5 with a stalled consumer
    dout_ready = 1'b0;
    go(5);
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("s2_hold_valid", 32'(dout_valid), 1);
      chk("s2_hold_dout", 32'(dout), 32'h10);
      chk("s2_hold_reB", 32'(reB), 0);
      cyc();
    end
    dout_ready = 1'b1;
    wait_done("s2");
    cyc();
    chk("s2_sb_empty", 32'(exp_d.size() + exp_a.size()), 0);

    // len=0: immediate done, no reads
    go(0);
    chk("s3_done", 32'(done), 1);
    chk("s3_busy", 32'(busy), 1);
    cyc();
    chk("s3_done_off", 32'(done), 0);
    chk("s3_busy_off", 32'(busy), 0);

    // len=17 clamps to 16; a start while busy is ignored
    base = rx_cnt;
    go(17);
    start = 1'b1;
    len = 5'd3;
    cyc();
    start = 1'b0;
    wait_done("s4");
    cyc();
    chk("s4_words", 32'(rx_cnt - base), 16);
    chk("s4_sb_empty", 32'(exp_d.size() + exp_a.size()), 0);
    cyc();

    // Reset in the middle of a len=8 burst, then a clean len=2 burst
    base = rx_cnt;
    go(8);
    for (int i = 0; i < 40 && rx_cnt < base + 3; i++) cyc();
    chk("s5_three_words", 32'(rx_cnt - base), 3);
    reset = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(dout_valid), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_reB", 32'(reB), 0);
    exp_d.delete();
    exp_a.delete();
    cyc();
    reset = 1'b1;
    cyc();
    base = rx_cnt;
    go(2);
    wait_done("s5b");
    cyc();
    chk("s5_words", 32'(rx_cnt - base), 2);
    chk("s5_sb_empty", 32'(exp_d.size() + exp_a.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
